// File: rtl/follower_pkg.sv
// Shared opcodes and FSM state type for the route command controller.
package follower_pkg;

    localparam logic [1:0] OP_STOP  = 2'b00;
    localparam logic [1:0] OP_GO    = 2'b01;
    localparam logic [1:0] OP_QUEUE = 2'b10;
    localparam logic [1:0] OP_RSVD  = 2'b11;

    typedef enum logic {
        IDLE    = 1'b0,
        TRANSIT = 1'b1
    } state_t;

endpackage

// File: rtl/dest_fifo.sv
// Circular destination queue; flush clears it and may load a first entry in the same cycle.
module dest_fifo #(
    parameter int ID_W  = 6,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic                       pop,
    input  logic                       flush,
    input  logic [ID_W-1:0]            din,
    output logic [ID_W-1:0]            head,
    output logic [$clog2(DEPTH+1)-1:0] cnt,
    output logic                       full,
    output logic                       empty
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH+1);

    logic [ID_W-1:0] mem [DEPTH];
    logic [PW-1:0]   rd_ptr;
    logic [PW-1:0]   wr_ptr;
    logic [CW-1:0]   count;
    logic            do_push;
    logic            do_pop;

    function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
        return (p == PW'(DEPTH-1)) ? '0 : p + 1'b1;
    endfunction

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && (flush || !full);
    assign do_pop  = pop && !empty && !flush;
    assign head    = empty ? '0 : mem[rd_ptr];
    assign cnt     = count;

    always_ff @(posedge clk) begin
        if (do_push)
            mem[flush ? '0 : wr_ptr] <= din;
    end

    // A flush with push leaves exactly the new entry at slot 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= do_push ? nxt('0) : '0;
            count  <= do_push ? CW'(1) : '0;
        end else begin
            if (do_push)
                wr_ptr <= nxt(wr_ptr);
            if (do_pop)
                rd_ptr <= nxt(rd_ptr);
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/route_cmd_cntrl.sv
// Multi-destination command controller: decodes route commands, tracks station matches,
// drives go toward motion control and a differential obstruction buzzer.
module route_cmd_cntrl
    import follower_pkg::*;
#(
    parameter int ID_W        = 6,
    parameter int DEPTH       = 4,
    parameter int BUZZ_PERIOD = 12500
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [ID_W+1:0]            cmd,
    input  logic                       cmd_rdy,
    output logic                       clr_cmd_rdy,
    input  logic [ID_W-1:0]            ID,
    input  logic                       ID_vld,
    output logic                       clr_ID_vld,
    input  logic                       OK2Move,
    output logic                       in_transit,
    output logic                       go,
    output logic                       buzz,
    output logic                       buzz_n,
    output logic [ID_W-1:0]            dest,
    output logic [$clog2(DEPTH+1)-1:0] q_cnt,
    output logic                       arrived,
    output logic                       cmd_err
);

    localparam int BW = (BUZZ_PERIOD > 2) ? $clog2(BUZZ_PERIOD) : 1;

    state_t          state;
    state_t          state_nxt;
    logic [1:0]      opcode;
    logic            push;
    logic            pop;
    logic            flush;
    logic            full;
    logic            empty;
    logic            err_nxt;
    logic            last_pop;
    logic            id_take;
    logic            en;
    logic [BW-1:0]   bcnt;

    assign opcode      = cmd[ID_W+1:ID_W];
    assign clr_cmd_rdy = cmd_rdy;
    assign id_take     = !cmd_rdy && ID_vld;
    assign clr_ID_vld  = id_take;
    assign go          = in_transit & OK2Move;

    dest_fifo #(.ID_W(ID_W), .DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (pop),
        .flush (flush),
        .din   (cmd[ID_W-1:0]),
        .head  (dest),
        .cnt   (q_cnt),
        .full  (full),
        .empty (empty)
    );

    // Commands take priority; station IDs are only acted on in cycles with no command.
    always_comb begin
        state_nxt = state;
        push      = 1'b0;
        pop       = 1'b0;
        flush     = 1'b0;
        err_nxt   = 1'b0;
        last_pop  = 1'b0;
        if (cmd_rdy) begin
            case (opcode)
                OP_STOP: begin
                    flush     = 1'b1;
                    state_nxt = IDLE;
                end
                OP_GO: begin
                    flush     = 1'b1;
                    push      = 1'b1;
                    state_nxt = TRANSIT;
                end
                OP_QUEUE: begin
                    if (full) begin
                        err_nxt = 1'b1;
                    end else begin
                        push      = 1'b1;
                        state_nxt = TRANSIT;
                    end
                end
                default: err_nxt = 1'b1;
            endcase
        end else if (id_take && state == TRANSIT && !empty && ID == dest) begin
            pop = 1'b1;
            if (q_cnt == 1) begin
                last_pop  = 1'b1;
                state_nxt = IDLE;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            in_transit <= 1'b0;
            arrived    <= 1'b0;
            cmd_err    <= 1'b0;
        end else begin
            state      <= state_nxt;
            in_transit <= (state_nxt == TRANSIT);
            arrived    <= last_pop;
            cmd_err    <= err_nxt;
        end
    end

    // Buzzer runs only while stalled in transit and restarts from zero each time.
    assign en     = in_transit & ~OK2Move;
    assign buzz_n = en ? ~buzz : 1'b0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bcnt <= '0;
            buzz <= 1'b0;
        end else if (!en) begin
            bcnt <= '0;
            buzz <= 1'b0;
        end else begin
            bcnt <= (bcnt == BW'(BUZZ_PERIOD-1)) ? '0 : bcnt + 1'b1;
            buzz <= (bcnt >= BW'(BUZZ_PERIOD/2));
        end
    end

endmodule

// File: tb/tb_route_cmd_cntrl.sv
// Directed bench for route_cmd_cntrl with a queue-based reference model checked every cycle.
module tb_route_cmd_cntrl;

    localparam int ID_W  = 6;
    localparam int DEPTH = 4;
    localparam int BP    = 8;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [ID_W+1:0] cmd = '0;
    logic            cmd_rdy = 1'b0;
    logic            clr_cmd_rdy;
    logic [ID_W-1:0] ID = '0;
    logic            ID_vld = 1'b0;
    logic            clr_ID_vld;
    logic            OK2Move = 1'b0;
    logic            in_transit;
    logic            go;
    logic            buzz;
    logic            buzz_n;
    logic [ID_W-1:0] dest;
    logic [2:0]      q_cnt;
    logic            arrived;
    logic            cmd_err;

    int errors = 0;
    int checks = 0;

    int mq[$];
    bit m_transit = 0;
    bit m_arrived = 0;
    bit m_err = 0;
    int m_en_edges = 0;

    route_cmd_cntrl #(.ID_W(ID_W), .DEPTH(DEPTH), .BUZZ_PERIOD(BP)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .cmd         (cmd),
        .cmd_rdy     (cmd_rdy),
        .clr_cmd_rdy (clr_cmd_rdy),
        .ID          (ID),
        .ID_vld      (ID_vld),
        .clr_ID_vld  (clr_ID_vld),
        .OK2Move     (OK2Move),
        .in_transit  (in_transit),
        .go          (go),
        .buzz        (buzz),
        .buzz_n      (buzz_n),
        .dest        (dest),
        .q_cnt       (q_cnt),
        .arrived     (arrived),
        .cmd_err     (cmd_err)
    );

    always #5 clk = ~clk;

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step();
        bit old_en;
        int op;
        old_en = m_transit && !OK2Move;
        m_en_edges = old_en ? m_en_edges + 1 : 0;
        m_arrived = 0;
        m_err = 0;
        if (cmd_rdy) begin
            op = int'(cmd[ID_W+1:ID_W]);
            case (op)
                0: begin mq.delete(); m_transit = 0; end
                1: begin mq.delete(); mq.push_back(int'(cmd[ID_W-1:0])); m_transit = 1; end
                2: begin
                    if (mq.size() == DEPTH) m_err = 1;
                    else begin mq.push_back(int'(cmd[ID_W-1:0])); m_transit = 1; end
                end
                default: m_err = 1;
            endcase
        end else if (ID_vld && m_transit && mq.size() > 0 && int'(ID) == mq[0]) begin
            void'(mq.pop_front());
            if (mq.size() == 0) begin
                m_transit = 0;
                m_arrived = 1;
            end
        end
    endtask

    initial forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            mq.delete();
            m_transit = 0;
            m_arrived = 0;
            m_err = 0;
            m_en_edges = 0;
        end else begin
            model_step();
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    initial forever begin
        bit exp_buzz;
        bit en_now;
        @(negedge clk);
        exp_buzz = (m_en_edges > 0) && (((m_en_edges - 1) % BP) >= BP/2);
        en_now = m_transit && !OK2Move;
        check_output("in_transit", in_transit, m_transit);
        check_output("dest", dest, mq.size() > 0 ? mq[0] : 0);
        check_output("q_cnt", q_cnt, mq.size());
        check_output("go", go, m_transit && OK2Move);
        check_output("arrived", arrived, m_arrived);
        check_output("cmd_err", cmd_err, m_err);
        check_output("clr_cmd_rdy", clr_cmd_rdy, cmd_rdy);
        check_output("clr_ID_vld", clr_ID_vld, !cmd_rdy && ID_vld);
        check_output("buzz", buzz, exp_buzz);
        check_output("buzz_n", buzz_n, en_now ? !exp_buzz : 1'b0);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_stimulus(input logic [1:0] op, input int id);
        cmd = {op, 6'(id)};
        cmd_rdy = 1'b1;
        #1;
        check_output("lit_clr_cmd_rdy", clr_cmd_rdy, 1);
        step();
        cmd_rdy = 1'b0;
    endtask

    task automatic send_id(input int id);
        ID = 6'(id);
        ID_vld = 1'b1;
        step();
        ID_vld = 1'b0;
    endtask

    initial begin
        repeat (3) step();
        check_output("lit_reset_transit", in_transit, 0);
        check_output("lit_reset_qcnt", q_cnt, 0);
        check_output("lit_reset_dest", dest, 0);
        rst_n = 1'b1;
        OK2Move = 1'b1;
        step();

        // GO 5, wrong ID, right ID
        apply_stimulus(2'b01, 5);
        check_output("lit_go_transit", in_transit, 1);
        check_output("lit_go_dest", dest, 5);
        check_output("lit_go_go", go, 1);
        send_id(3);
        check_output("lit_wrong_id_transit", in_transit, 1);
        send_id(5);
        check_output("lit_arrived_pulse", arrived, 1);
        check_output("lit_arrived_idle", in_transit, 0);
        step();
        check_output("lit_arrived_low", arrived, 0);

        // ID while idle is ignored
        send_id(5);
        check_output("lit_idle_id", in_transit, 0);

        // QUEUE 1,2,3 and walk the route
        apply_stimulus(2'b10, 1);
        apply_stimulus(2'b10, 2);
        apply_stimulus(2'b10, 3);
        check_output("lit_q3_cnt", q_cnt, 3);
        check_output("lit_q3_dest", dest, 1);
        send_id(1);
        check_output("lit_step_dest2", dest, 2);
        send_id(2);
        check_output("lit_step_dest3", dest, 3);
        check_output("lit_no_early_arrive", arrived, 0);
        send_id(3);
        check_output("lit_final_arrive", arrived, 1);
        step();

        // Overflow on the fifth QUEUE
        for (int i = 0; i < 5; i++) apply_stimulus(2'b10, 10 + i);
        check_output("lit_full_err", cmd_err, 1);
        check_output("lit_full_cnt", q_cnt, 4);
        check_output("lit_full_dest", dest, 10);
        apply_stimulus(2'b11, 0);
        check_output("lit_rsvd_err", cmd_err, 1);
        check_output("lit_rsvd_cnt", q_cnt, 4);
        for (int i = 0; i < 4; i++) begin
            check_output("lit_full_contents", dest, 10 + i);
            send_id(10 + i);
        end
        check_output("lit_full_arrive", arrived, 1);
        check_output("lit_full_empty", q_cnt, 0);

        // STOP mid-transit while buzzing
        apply_stimulus(2'b10, 1);
        apply_stimulus(2'b10, 2);
        apply_stimulus(2'b10, 3);
        OK2Move = 1'b0;
        repeat (7) step();
        apply_stimulus(2'b00, 0);
        check_output("lit_stop_cnt", q_cnt, 0);
        check_output("lit_stop_transit", in_transit, 0);
        check_output("lit_stop_buzzn", buzz_n, 0);
        step();
        check_output("lit_stop_buzz", buzz, 0);

        // Buzzer waveform with BUZZ_PERIOD=8
        OK2Move = 1'b1;
        apply_stimulus(2'b01, 9);
        OK2Move = 1'b0;
        repeat (4) step();
        check_output("lit_buzz_pre", buzz, 0);
        step();
        check_output("lit_buzz_rise", buzz, 1);
        check_output("lit_buzzn_rise", buzz_n, 0);
        repeat (3) step();
        check_output("lit_buzz_high", buzz, 1);
        step();
        check_output("lit_buzz_fall", buzz, 0);
        check_output("lit_buzzn_fall", buzz_n, 1);
        check_output("lit_buzz_go", go, 0);
        repeat (15) step();
        OK2Move = 1'b1;
        step();
        check_output("lit_buzz_off", buzz, 0);

        // Command and matching ID in the same cycle
        cmd = {2'b10, 6'd7};
        cmd_rdy = 1'b1;
        ID = 6'd9;
        ID_vld = 1'b1;
        #1;
        check_output("lit_sim_clr_cmd", clr_cmd_rdy, 1);
        check_output("lit_sim_clr_id0", clr_ID_vld, 0);
        step();
        cmd_rdy = 1'b0;
        #1;
        check_output("lit_sim_clr_id1", clr_ID_vld, 1);
        check_output("lit_sim_cnt2", q_cnt, 2);
        step();
        ID_vld = 1'b0;
        check_output("lit_sim_dest", dest, 7);
        check_output("lit_sim_cnt1", q_cnt, 1);
        send_id(7);
        check_output("lit_sim_arrive", arrived, 1);

        // Asynchronous reset mid-transit
        apply_stimulus(2'b01, 4);
        apply_stimulus(2'b10, 6);
        OK2Move = 1'b0;
        repeat (6) step();
        rst_n = 1'b0;
        #1;
        check_output("lit_rst_transit", in_transit, 0);
        check_output("lit_rst_cnt", q_cnt, 0);
        check_output("lit_rst_buzz", buzz, 0);
        check_output("lit_rst_dest", dest, 0);
        step();
        rst_n = 1'b1;
        OK2Move = 1'b1;
        repeat (2) step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/route_cmd_cntrl.md
# route_cmd_cntrl

Parametrised successor to the follower's single-destination command controller. Decodes commands from the UART/command path, holds a queue of up to DEPTH destination IDs, and keeps the robot in transit until every queued station ID has been matched by the ID reader. Also drives `go` toward the motion controller and generates an obstruction buzzer with a configurable period. Sits between the command receiver, the station-ID receiver and the motion/piezo logic.

## Interface
Parameters:
- `ID_W`, default 6: width of a station ID. The command word is `ID_W+2` bits wide.
- `DEPTH`, default 4: number of destination-queue entries. Must be at least 1.
- `BUZZ_PERIOD`, default 12500: buzzer period in clk cycles (4 kHz at 50 MHz). Must be even and at least 2.

Ports:
- `clk`  in  1  clock
- `rst_n`  in  1  reset, asynchronous, active-low
- `cmd`  in  ID_W+2  bits [ID_W+1:ID_W] are the opcode; bits [ID_W-1:0] are the destination ID
- `cmd_rdy`  in  1  a command is valid
- `clr_cmd_rdy`  out  1  command consumed (combinational)
- `ID`  in  ID_W  station ID read from the track
- `ID_vld`  in  1  `ID` is valid
- `clr_ID_vld`  out  1  ID consumed (combinational)
- `OK2Move`  in  1  path is clear
- `in_transit`  out  1  registered; high while in TRANSIT
- `go`  out  1  `in_transit & OK2Move`
- `buzz`, `buzz_n`  out  1  differential piezo drive
- `dest`  out  ID_W  head of the queue (current target); 0 when the queue is empty
- `q_cnt`  out  $clog2(DEPTH+1)  number of queued entries
- `arrived`  out  1  one-cycle pulse when the final destination is matched
- `cmd_err`  out  1  one-cycle pulse when a command is dropped

## Operation
- Opcodes:
  - 00 STOP: flush the queue and go to IDLE.
  - 01 GO: flush the queue, load `cmd[ID_W-1:0]` as the single entry, and go to TRANSIT.
  - 10 QUEUE: append the ID. If in IDLE, go to TRANSIT. If the queue is full, drop the ID, pulse `cmd_err`, and leave state unchanged.
  - 11 reserved: ignore and pulse `cmd_err`.
- Every command is consumed in the cycle it is seen: `clr_cmd_rdy = cmd_rdy`.
- FSM states are IDLE and TRANSIT; `in_transit` is the registered decode of TRANSIT.
- ID handling applies only when `cmd_rdy` is low and `ID_vld` is high. `clr_ID_vld` is asserted in that cycle.
  - In TRANSIT, if `ID == dest`, pop the queue. If it is now empty, go to IDLE and pulse `arrived` on the next cycle. Otherwise stay in TRANSIT, targeting the new head.
  - A non-matching ID, or any ID seen in IDLE, is cleared and ignored.
- Simultaneous `cmd_rdy` and `ID_vld`: the command wins. `ID_vld` is not cleared and is handled on the next cycle. Push and pop therefore never occur in the same cycle.
- Buzzer enable is `en = in_transit & ~OK2Move`.
  - While `en` is high, counter `bcnt` counts 0..BUZZ_PERIOD-1 and wraps.
  - `buzz` is registered as `(bcnt >= BUZZ_PERIOD/2)`.
  - `buzz_n = en ? ~buzz : 1'b0`.
  - When `en` is low, `bcnt` and `buzz` are forced to 0 on the next edge.
- The queue is a circular buffer with read and write pointers that wrap modulo DEPTH. `q_cnt` never exceeds DEPTH. A flush resets both pointers and the count.

## Timing
- Reset values: state IDLE; `in_transit`, `go`, `buzz`, `buzz_n`, `arrived`, `cmd_err` and `q_cnt` all 0; `dest` 0; `bcnt` 0.
- `clr_cmd_rdy` and `clr_ID_vld` are asserted in the same cycle as their request. Upstream must drop the request by the next edge.
- `cmd_rdy` accepted at edge N: `in_transit` and `dest` update at N+1, and `go` follows at N+1.
- Final match at edge N: `in_transit` goes to 0 and `arrived` goes to 1 at N+1. `arrived` is low again at N+2.
- `cmd_err` is a registered pulse at N+1.
- The first buzzer edge comes BUZZ_PERIOD/2+1 cycles after `en` rises.
- Reset asserted mid-transit immediately clears the queue, the FSM and the buzzer.

## Structure
- Package `follower_pkg`: opcode localparams (`OP_STOP`, `OP_GO`, `OP_QUEUE`, `OP_RSVD`) and the state enum.
- Sub-module `dest_fifo` (parameters ID_W and DEPTH; inputs push, pop, flush; outputs head, cnt, full, empty). The FSM and buzzer stay in the top module.

## Test plan
- Reset, then GO id=5 → `clr_cmd_rdy` 1 for one cycle; `in_transit` 1 and `dest` 5 next cycle; ID 3 → cleared, still in transit; ID 5 → `arrived` pulse and `in_transit` 0.
- QUEUE 1, 2, 3 from IDLE → `q_cnt` 3 and `dest` 1; IDs 1, 2, 3 in order → `dest` steps 1→2→3, and `arrived` pulses only after 3.
- With DEPTH=4, five QUEUE commands → fifth raises `cmd_err`; `q_cnt` stays 4 and the contents are unchanged.
- STOP mid-transit with 3 entries → `q_cnt` 0, `in_transit` 0, `buzz` and `buzz_n` 0 within one cycle.
- In TRANSIT, `OK2Move`=0 for 3×BUZZ_PERIOD cycles (use BUZZ_PERIOD=8) → `buzz` square wave of period 8 with `buzz_n` = ~`buzz`; `go` 0.
- `cmd_rdy` (QUEUE 7) and matching `ID_vld` in the same cycle → only `clr_cmd_rdy` that cycle; `clr_ID_vld` the next cycle, and the pop then happens.
